// File: rtl/pcie_irq_pkg.sv
// Shared definitions for the N-source PCIe interrupt controller.
//   irq_state_e   : controller state encoding
//   ACK_PULSE_CYC : width in cycles of each per-source acknowledge pulse
//   lowest_set()  : index of the lowest set bit of a 32-bit vector
//   vec_clamp()   : MSI vector selection limited by the granted vector count
package pcie_irq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_RD  = 3'd2,
    WAIT_ACK = 3'd3,
    DEASSERT = 3'd4,
    HOLDOFF  = 3'd5
  } irq_state_e;

  localparam int unsigned ACK_PULSE_CYC = 2;

  // Scanning from the top down leaves the lowest set index in idx.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // The core grants 2^mm vectors; MSI can address at most 32 of them.
  // Sources above the last granted vector share that last vector.
  function automatic logic [7:0] vec_clamp(input logic [4:0] idx,
                                           input logic [2:0] mm);
    logic [2:0] e;
    logic [5:0] lim;
    e   = (mm > 3'd5) ? 3'd5 : mm;
    lim = (6'd1 << e) - 6'd1;
    return ({1'b0, idx} > lim) ? {2'b00, lim} : {3'b000, idx};
  endfunction

endpackage

// File: rtl/irq_pending_bank.sv
// Per-source pending registers and acknowledge pulse stretchers.
//   clk, rst  : clock and synchronous active-high reset
//   set       : per-source event pulses (set the pending bit)
//   clr_en    : qualified CPU acknowledge strobe
//   clr_bits  : pending bits to clear when clr_en is high
//   pending   : live pending bits
//   ack       : per-source acknowledge pulse, ACK_PULSE_CYC cycles long
module irq_pending_bank
  import pcie_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] set,
  input  logic               clr_en,
  input  logic [NUM_SRC-1:0] clr_bits,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] ack
);

  logic [NUM_SRC-1:0][1:0] ack_cnt;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ack_cnt <= '0;
    end else begin
      // The set term is ORed last so an event coinciding with its own
      // acknowledge is never lost.
      pending <= (pending & ~(clr_en ? clr_bits : '0)) | set;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (clr_en && clr_bits[i]) begin
          ack_cnt[i] <= 2'(ACK_PULSE_CYC);
        end else if (ack_cnt[i] != 2'd0) begin
          ack_cnt[i] <= ack_cnt[i] - 2'd1;
        end
      end
    end
  end

  // NOTE: a full default assignment before the loop keeps this block
  // purely combinational; no path leaves ack unassigned.
  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack[i] = |ack_cnt[i];
    end
  end

endmodule

// File: rtl/pcie_irq_ctrl_nch.sv
// N-source PCIe interrupt controller driving the core cfg_interrupt handshake.
// Pending events gated by a CPU mask raise an MSI (vector = lowest pending
// source, clamped to the granted count) or a legacy INTx assert. The
// controller then waits for the CPU to read the type register and
// acknowledge, re-sending on timeout a bounded number of times. Legacy
// interrupts finish with an INTx deassert message; every completed
// interrupt is followed by a short hold-off.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   i_irq_req / i_irq_mask        : per-source events / enables
//   i_cpu_rd_type_en              : CPU read strobe of o_irq_type_reg
//   i_cpu_ack_en / i_cpu_ack_bits : CPU acknowledge strobe and bits to clear
//   o_irq_type_reg                : snapshot of (pending & mask) at start
//   o_irq_ack                     : per-source acknowledge pulses
//   o_pending                     : live pending bits
//   o_irq_cnt / o_timeout_cnt     : started (wraps) / abandoned (saturates)
//   cfg_*                         : PCIe core interrupt interface
module pcie_irq_ctrl_nch
  import pcie_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter logic [31:0] TIMEOUT_CYC = 32'h0100_0000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned HOLDOFF_CYC = 4,
  parameter logic [4:0]  MSG_NUM     = 5'h05
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] i_irq_req,
  input  logic [NUM_SRC-1:0] i_irq_mask,
  input  logic               i_cpu_rd_type_en,
  input  logic               i_cpu_ack_en,
  input  logic [NUM_SRC-1:0] i_cpu_ack_bits,
  output logic [NUM_SRC-1:0] o_irq_type_reg,
  output logic [NUM_SRC-1:0] o_irq_ack,
  output logic [NUM_SRC-1:0] o_pending,
  output logic [31:0]        o_irq_cnt,
  output logic [15:0]        o_timeout_cnt,
  output logic               cfg_interrupt,
  input  logic               cfg_interrupt_rdy,
  output logic               cfg_interrupt_assert,
  output logic [7:0]         cfg_interrupt_di,
  input  logic               cfg_interrupt_msienable,
  input  logic [2:0]         cfg_interrupt_mmenable,
  output logic               cfg_interrupt_stat,
  output logic [4:0]         cfg_pciecap_interrupt_msgnum
);

  irq_state_e         state;
  logic               msi_mode;
  logic [31:0]        retry_cnt;
  logic [31:0]        timer;
  logic [31:0]        hold_cnt;
  logic               ack_clr;
  logic [NUM_SRC-1:0] masked;
  logic [7:0]         vec;

  assign cfg_interrupt_stat           = 1'b0;
  assign cfg_pciecap_interrupt_msgnum = MSG_NUM;

  // Pending bits may only be cleared once the CPU has read the type register.
  assign ack_clr = (state == WAIT_ACK) && i_cpu_ack_en;
  assign masked  = o_pending & i_irq_mask;
  assign vec     = vec_clamp(lowest_set(32'(masked)), cfg_interrupt_mmenable);

  irq_pending_bank #(
    .NUM_SRC (NUM_SRC)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .set      (i_irq_req),
    .clr_en   (ack_clr),
    .clr_bits (i_cpu_ack_bits),
    .pending  (o_pending),
    .ack      (o_irq_ack)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      msi_mode             <= 1'b0;
      retry_cnt            <= '0;
      timer                <= '0;
      hold_cnt             <= '0;
      o_irq_type_reg       <= '0;
      o_irq_cnt            <= '0;
      o_timeout_cnt        <= '0;
      cfg_interrupt        <= 1'b0;
      cfg_interrupt_assert <= 1'b0;
      cfg_interrupt_di     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Mode, mask and vector are frozen here for the whole interrupt.
          if (|masked) begin
            o_irq_type_reg       <= masked;
            msi_mode             <= cfg_interrupt_msienable;
            cfg_interrupt_di     <= cfg_interrupt_msienable ? vec : 8'd0;
            cfg_interrupt_assert <= ~cfg_interrupt_msienable;
            cfg_interrupt        <= 1'b1;
            retry_cnt            <= '0;
            o_irq_cnt            <= o_irq_cnt + 32'd1;
            state                <= SEND;
          end
        end

        SEND: begin
          if (cfg_interrupt_rdy) begin
            cfg_interrupt <= 1'b0;
            timer         <= '0;
            state         <= WAIT_RD;
          end
        end

        WAIT_RD: begin
          if (timer != '1) timer <= timer + 32'd1;
          if (i_cpu_rd_type_en) begin
            state <= WAIT_ACK;
          end else if (timer >= TIMEOUT_CYC) begin
            if (retry_cnt < MAX_RETRY) begin
              // Legacy INTx stays asserted across the re-send.
              retry_cnt     <= retry_cnt + 32'd1;
              cfg_interrupt <= 1'b1;
              state         <= SEND;
            end else begin
              // Abandon; pending bits stay set so IDLE re-raises them.
              if (o_timeout_cnt != '1) o_timeout_cnt <= o_timeout_cnt + 16'd1;
              cfg_interrupt_assert <= 1'b0;
              state                <= IDLE;
            end
          end
        end

        WAIT_ACK: begin
          if (i_cpu_ack_en) begin
            if (msi_mode) begin
              hold_cnt <= '0;
              state    <= HOLDOFF;
            end else begin
              cfg_interrupt        <= 1'b1;
              cfg_interrupt_assert <= 1'b0;
              state                <= DEASSERT;
            end
          end
        end

        DEASSERT: begin
          if (cfg_interrupt_rdy) begin
            cfg_interrupt <= 1'b0;
            hold_cnt      <= '0;
            state         <= HOLDOFF;
          end
        end

        HOLDOFF: begin
          if (hold_cnt + 32'd1 >= HOLDOFF_CYC) state <= IDLE;
          else hold_cnt <= hold_cnt + 32'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_irq_ctrl_nch.sv
// Scoreboard bench for pcie_irq_ctrl_nch. The stimulus side keeps a
// behavioural model (pending set, mask, mode, counters) and pushes the
// expected handshake contents; a monitor pops them on every
// cfg_interrupt/cfg_interrupt_rdy handshake. The core side answers rdy
// after a random delay.
module tb_pcie_irq_ctrl_nch;

  localparam int N    = 8;
  localparam int HOLD = 4;

  typedef struct {
    logic         as;
    logic [7:0]   di;
    logic [N-1:0] ty;
  } hs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq_req = '0;
  logic [N-1:0] irq_mask = '0;
  logic         rd_en = 1'b0;
  logic         ack_en = 1'b0;
  logic [N-1:0] ack_bits = '0;
  logic [N-1:0] type_reg, irq_ack, pending;
  logic [31:0]  irq_cnt;
  logic [15:0]  timeout_cnt;
  logic         cfg_int, cfg_assert, cfg_stat;
  logic         cfg_rdy = 1'b0;
  logic [7:0]   cfg_di;
  logic         msien = 1'b1;
  logic [2:0]   mmen = 3'd3;
  logic [4:0]   msgnum;

  int  checks = 0;
  int  errors = 0;
  int  hs_count = 0;
  int  hs_exp = 0;
  bit  rdy_en = 1'b1;
  hs_t exp_q[$];

  // Reference model state
  logic [N-1:0] pend_m = '0;
  logic [N-1:0] mask_m = '0;
  logic         msi_m = 1'b1;
  logic [2:0]   mm_m = 3'd3;
  logic [N-1:0] cur_ty = '0;
  int           cnt_m = 0;
  int           tmo_m = 0;

  always #5 clk = ~clk;

  pcie_irq_ctrl_nch #(
    .NUM_SRC     (N),
    .TIMEOUT_CYC (32'd16),
    .MAX_RETRY   (2),
    .HOLDOFF_CYC (HOLD),
    .MSG_NUM     (5'h05)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .i_irq_req                    (irq_req),
    .i_irq_mask                   (irq_mask),
    .i_cpu_rd_type_en             (rd_en),
    .i_cpu_ack_en                 (ack_en),
    .i_cpu_ack_bits               (ack_bits),
    .o_irq_type_reg               (type_reg),
    .o_irq_ack                    (irq_ack),
    .o_pending                    (pending),
    .o_irq_cnt                    (irq_cnt),
    .o_timeout_cnt                (timeout_cnt),
    .cfg_interrupt                (cfg_int),
    .cfg_interrupt_rdy            (cfg_rdy),
    .cfg_interrupt_assert         (cfg_assert),
    .cfg_interrupt_di             (cfg_di),
    .cfg_interrupt_msienable      (msien),
    .cfg_interrupt_mmenable       (mmen),
    .cfg_interrupt_stat           (cfg_stat),
    .cfg_pciecap_interrupt_msgnum (msgnum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector from the rules: lowest requesting source, limited to 2^min(mm,5)-1.
  function automatic logic [7:0] exp_vec(input logic [N-1:0] t, input logic msi, input logic [2:0] mm);
    int idx, e, lim;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) if (t[i]) idx = i;
    e   = (mm > 5) ? 5 : int'(mm);
    lim = (1 << e) - 1;
    if (!msi) return 8'd0;
    return 8'((idx < lim) ? idx : lim);
  endfunction

  // Core model: accept each request after 0..3 cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (cfg_int && rdy_en && !rst) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        cfg_rdy = 1'b1;
        @(posedge clk); #1;
        cfg_rdy = 1'b0;
      end
    end
  end

  // Monitor: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && cfg_int && cfg_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: got assert=%0b di=%0d type=0x%0h, expected none", cfg_assert, cfg_di, type_reg);
      end else begin
        hs_t e;
        e = exp_q.pop_front();
        check("hs_assert", 32'(cfg_assert), 32'(e.as));
        check("hs_di", 32'(cfg_di), 32'(e.di));
        check("hs_type", 32'(type_reg), 32'(e.ty));
      end
      hs_count++;
    end
  end

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (hs_count < target) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got %0d handshakes, expected %0d", hs_count, target);
    end
    @(negedge clk);
  endtask

  task automatic expect_irq(input int sends);
    hs_t e;
    cur_ty = pend_m & mask_m;
    e.ty = cur_ty;
    e.as = ~msi_m;
    e.di = exp_vec(cur_ty, msi_m, mm_m);
    for (int s = 0; s < sends; s++) exp_q.push_back(e);
    if (!msi_m) begin
      e.as = 1'b0;
      exp_q.push_back(e);
    end
    hs_exp += sends;
    cnt_m++;
  endtask

  // Called at a negedge while the controller is idle with nothing to do.
  task automatic trigger(input logic [N-1:0] req, input logic [N-1:0] mask,
                         input logic msi, input logic [2:0] mm, input int sends);
    bit fire;
    irq_req = req;
    pend_m |= req;
    mask_m = mask;
    msi_m  = msi;
    mm_m   = mm;
    fire   = (pend_m & mask_m) != '0;
    if (fire) expect_irq(sends);
    @(negedge clk);
    irq_req  = '0;
    irq_mask = mask;
    msien    = msi;
    mmen     = mm;
    check("pending_set", 32'(pending), 32'(pend_m));
    check("no_early_irq", 32'(cfg_int), 32'd0);
    if (fire) begin
      @(negedge clk);
      check("irq_latency", 32'(cfg_int), 32'd1);
    end
  endtask

  task automatic handle_irq(input logic [N-1:0] ack_b, input logic [N-1:0] req_rd,
                            input logic [N-1:0] req_ack);
    wait_hs(hs_exp);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    check("type_reg", 32'(type_reg), 32'(cur_ty));
    check("irq_cnt", irq_cnt, 32'(cnt_m));
    rd_en   = 1'b1;
    irq_req = req_rd;
    @(negedge clk);
    rd_en   = 1'b0;
    irq_req = '0;
    pend_m |= req_rd;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    ack_en   = 1'b1;
    ack_bits = ack_b;
    irq_req  = req_ack;
    @(negedge clk);
    ack_en   = 1'b0;
    ack_bits = '0;
    irq_req  = '0;
    pend_m = (pend_m & ~ack_b) | req_ack;
    check("ack_pulse_1", 32'(irq_ack), 32'(ack_b));
    check("pending_after_ack", 32'(pending), 32'(pend_m));
    @(negedge clk);
    check("ack_pulse_2", 32'(irq_ack), 32'(ack_b));
    @(negedge clk);
    check("ack_pulse_end", 32'(irq_ack), 32'd0);
    if (!msi_m) begin
      hs_exp++;
      wait_hs(hs_exp);
    end
  endtask

  // Service re-fires from leftover pending bits until nothing is requesting.
  task automatic settle(input bit rnd);
    int guard = 0;
    while ((pend_m & mask_m) != '0 && guard < 8) begin
      expect_irq(1);
      handle_irq((rnd && guard < 3) ? N'($urandom) : '1, '0, '0);
      guard++;
    end
    repeat (HOLD + 4) @(negedge clk);
    check("idle_after_settle", 32'(cfg_int), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_type", 32'(type_reg), 32'd0);
    check("rst_irq_cnt", irq_cnt, 32'd0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    check("rst_cfg_int", 32'(cfg_int), 32'd0);
    check("rst_assert", 32'(cfg_assert), 32'd0);
    check("rst_di", 32'(cfg_di), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ack", 32'(irq_ack), 32'd0);
    check("stat_tied", 32'(cfg_stat), 32'd0);
    check("msgnum", 32'(msgnum), 32'h05);

    // MSI, source 5, full grant
    trigger(8'h20, 8'hFF, 1'b1, 3'd3, 1);
    handle_irq(8'h20, '0, '0);
    settle(1'b0);

    // MSI, two sources, index clamped; partial ack re-fires the rest
    trigger(8'h48, 8'hFF, 1'b1, 3'd1, 1);
    handle_irq(8'h08, '0, '0);
    settle(1'b0);

    // Legacy INTx with deassert message
    trigger(8'h01, 8'hFF, 1'b0, 3'd0, 1);
    handle_irq(8'h01, '0, '0);
    settle(1'b0);

    // No CPU read: initial send + 2 retries, then abandon and re-fire
    trigger(8'h10, 8'hFF, 1'b1, 3'd3, 3);
    wait_hs(hs_exp);
    tmo_m++;
    expect_irq(1);
    handle_irq(8'h10, '0, '0);
    check("timeout_cnt", 32'(timeout_cnt), 32'(tmo_m));
    settle(1'b0);

    // New event on source 2 in the same cycle as its acknowledge
    trigger(8'h04, 8'hFF, 1'b1, 3'd3, 1);
    handle_irq(8'h04, '0, 8'h04);
    settle(1'b0);

    // Randomised traffic
    for (int it = 0; it < 30; it++) begin
      logic [N-1:0] mk;
      mk = N'($urandom) | N'($urandom);
      trigger(N'($urandom), mk, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1);
      if ((pend_m & mask_m) != '0)
        handle_irq(N'($urandom), N'($urandom & $urandom & $urandom), N'($urandom & $urandom & $urandom));
      settle(1'b1);
    end

    check("timeout_cnt_final", 32'(timeout_cnt), 32'(tmo_m));
    check("irq_cnt_final", irq_cnt, 32'(cnt_m));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("handshake_total", 32'(hs_count), 32'(hs_exp));

    // Reset while stuck in SEND (legacy, core never ready)
    rdy_en = 1'b0;
    irq_mask = 8'hFF;
    msien = 1'b0;
    irq_req = 8'h02;
    @(negedge clk);
    irq_req = '0;
    begin
      int n = 0;
      while (!cfg_int && n < 20) begin @(negedge clk); n++; end
    end
    check("reset_test_sending", 32'(cfg_int), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cfg_int", 32'(cfg_int), 32'd0);
    check("mid_rst_assert", 32'(cfg_assert), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_irq_cnt", irq_cnt, 32'd0);
    check("mid_rst_type", 32'(type_reg), 32'd0);
    rst = 1'b0;
    rdy_en = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_quiet", 32'(cfg_int), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_irq_ctrl_nch.md
Name: pcie_irq_ctrl_nch

Overview:
- Parametrised N-source PCIe interrupt controller. Next generation of the single-vector link/DMA interrupt block.
- Collects per-source event pulses into pending bits and gates them with a CPU mask.
- Raises MSI (multi-vector) or legacy INTx through the PCIe core cfg_interrupt handshake, then holds off until the CPU has read the type register and acknowledged.
- Adds timeout retry with a bounded count, per-source ack pulses, and a proper INTx deassert message.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32).
- TIMEOUT_CYC, 32'h0100_0000, cycles waited in WAIT_RD before re-sending the interrupt.
- MAX_RETRY, 3, re-sends allowed before abandoning the current interrupt.
- HOLDOFF_CYC, 4, idle gap after a completed interrupt before the next one may start.
- MSG_NUM, 5'h05, value driven on cfg_pciecap_interrupt_msgnum.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- i_irq_req  in  NUM_SRC  per-source event pulse; sets the pending bit.
- i_irq_mask  in  NUM_SRC  1 = source permitted to interrupt.
- i_cpu_rd_type_en  in  1  CPU read strobe for the type register.
- i_cpu_ack_en  in  1  CPU acknowledge write strobe.
- i_cpu_ack_bits  in  NUM_SRC  pending bits to clear on ack.
- o_irq_type_reg  out  NUM_SRC  latched snapshot of (pending & mask).
- o_irq_ack  out  NUM_SRC  per-source 2-cycle ack pulse.
- o_pending  out  NUM_SRC  live pending bits.
- o_irq_cnt  out  32  count of interrupts started; wraps.
- o_timeout_cnt  out  16  count of abandoned interrupts; saturates.
- cfg_interrupt  out  1  request to the PCIe core.
- cfg_interrupt_rdy  in  1  PCIe core accept.
- cfg_interrupt_assert  out  1  INTx level (legacy mode only).
- cfg_interrupt_di  out  8  MSI vector.
- cfg_interrupt_msienable  in  1  MSI mode enable.
- cfg_interrupt_mmenable  in  3  log2 of vectors granted.
- cfg_interrupt_stat  out  1  tied 0.
- cfg_pciecap_interrupt_msgnum  out  5  equals MSG_NUM.

Behaviour:
- Reset: every output register is 0, state is IDLE, pending is 0, retry_cnt is 0.
  - Reset mid-handshake drops cfg_interrupt and cfg_interrupt_assert at the next edge.
  - No deassert message is sent on reset.
- Pending bit i:
  - Set by i_irq_req[i].
  - Cleared when in WAIT_ACK and i_cpu_ack_en is high and i_cpu_ack_bits[i] is 1.
  - Simultaneous set and clear: set wins, so a new event is never lost.
- IDLE: if |(pending & i_irq_mask), latch o_irq_type_reg, latch mode (msienable), compute vector, clear retry_cnt, increment o_irq_cnt, then go to SEND.
- Vector:
  - idx = lowest set bit of the type register.
  - lim = 2^min(mmenable,5) - 1.
  - di = min(idx, lim) in MSI mode; di = 0 in legacy mode.
  - di is held stable from SEND until IDLE.
- SEND: cfg_interrupt = 1. In legacy mode cfg_interrupt_assert = 1 as well.
  - Stay until cfg_interrupt_rdy is sampled high.
  - cfg_interrupt falls on the edge after rdy.
  - Then go to WAIT_RD and clear the timer.
- WAIT_RD:
  - i_cpu_rd_type_en -> WAIT_ACK.
  - Else, timer reaching TIMEOUT_CYC -> SEND with retry_cnt+1 if retry_cnt < MAX_RETRY.
  - Otherwise -> IDLE with o_timeout_cnt+1. Pending bits are retained, so the interrupt re-fires after IDLE re-evaluates.
  - Legacy retry keeps cfg_interrupt_assert high.
- WAIT_ACK: on i_cpu_ack_en:
  - Clear pending bits.
  - Pulse o_irq_ack[i] for 2 cycles for each set i_cpu_ack_bits[i].
  - Legacy mode -> DEASSERT; MSI mode -> HOLDOFF.
  - No timeout in this state.
- DEASSERT: cfg_interrupt = 1 and cfg_interrupt_assert = 0 until rdy, then HOLDOFF.
- HOLDOFF: count HOLDOFF_CYC cycles, then IDLE.
- Changes of mask or msienable mid-transaction do not affect the current interrupt; they are re-evaluated in IDLE.
- Timer is 32 bit and saturates. o_irq_cnt wraps at 2^32.
- Latency: IDLE to cfg_interrupt high is 2 cycles after the pending bit is set.

Decomposition:
- Package pcie_irq_pkg holds:
  - state encoding: IDLE, SEND, WAIT_RD, WAIT_ACK, DEASSERT, HOLDOFF;
  - the vector clamp function;
  - the 2-cycle ack-pulse width constant.
- One sub-module, irq_pending_bank: per-source pending registers with set-wins logic and ack pulse stretchers, NUM_SRC wide.

Test Plan:
- MSI, mmenable=3, pulse i_irq_req[5] with mask all 1 -> cfg_interrupt high 2 cycles later, di=5, type=0x20. Read, then ack 0x20 -> o_irq_ack[5] high 2 cycles, pending 0, o_irq_cnt=1.
- MSI, mmenable=1, pulse req[6] and req[3] in the same cycle -> type=0x48, di=1 (idx 3 clamped to lim 1). Ack 0x08 only -> after HOLDOFF a second interrupt fires with type=0x40.
- Legacy (msienable=0), pulse req[0] -> assert=1 with cfg_interrupt. Read and ack -> second handshake with assert=0, then HOLDOFF, then IDLE.
- TIMEOUT_CYC=16, MAX_RETRY=2, rdy answered, no CPU read -> 3 total sends, then IDLE with o_timeout_cnt=1. The pending bit still 1 retriggers.
- In WAIT_ACK, req[2] pulses in the same cycle as ack bit 2 -> pending[2] stays 1 and a new interrupt follows.
- rst asserted while in SEND with rdy low -> next edge cfg_interrupt=0, pending=0, state IDLE.
